// File: rtl/whack_pkg.sv
// -----------------------------------------------------------------------------
// whack_pkg
// Shared definitions for the Whack-A-Mole score path.
//   state_t          : round sequencer states (IDLE, CLEAR, PLAY, OVER)
//   SCORE_W/SCORE_MAX: width and ceiling of the external score counter
//   TIME_W           : width of the round timer
//   score_saturated(): true when one more increment would overflow the
//                      counter, taking an increment already on the wire
//                      into account
// -----------------------------------------------------------------------------
package whack_pkg;

    localparam int SCORE_W   = 8;
    localparam int SCORE_MAX = 255;
    localparam int TIME_W    = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } state_t;

    // The counter output is registered, so an increment issued this cycle is
    // not yet visible on 'score'. Treat 254 plus a pending increment as full.
    function automatic logic score_saturated(input logic [SCORE_W-1:0] score,
                                             input logic               inc_pending);
        return (score == SCORE_W'(SCORE_MAX)) ||
               (inc_pending && (score == SCORE_W'(SCORE_MAX - 1)));
    endfunction

endpackage

// File: rtl/whack_score_ctrl_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Generic round-robin arbiter with a registered priority pointer.
//   clock   : system clock (rising edge)
//   reset   : asynchronous active-low reset, pointer returns to index 0
//   req     : N request bits
//   mask    : N bits that are excluded from this cycle's decision
//   advance : when high, a grant moves the pointer one past the winner
//   grant   : one-hot (or zero) combinational grant
// The grant is combinational so the caller decides where to register it.
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] next_ptr;
    logic [PW-1:0] idx;
    logic          found;

    // Scan starting at the pointer and wrap; the first eligible index wins.
    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        idx      = '0;
        found    = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx] && !mask[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
                next_ptr   = PW'((int'(idx) + 1) % N);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= next_ptr;
        end
    end

endmodule

// File: rtl/whack_score_ctrl.sv
// -----------------------------------------------------------------------------
// whack_score_ctrl
// Round sequencer and hit arbiter in front of the 8-bit score counter.
//   clock     : system clock (rising edge)
//   reset     : asynchronous active-low reset
//   start     : pulse, begins a round from IDLE or OVER
//   tick      : one-cycle time-base enable
//   hit_req   : per-mole level requests, held until acknowledged
//   hit_ack   : one-hot, one-cycle acknowledge (registered)
//   score     : current counter value (registered counter output)
//   score_clr : one-cycle clear to the counter
//   score_inc : one-cycle increment to the counter
//   time_left : ticks remaining in the round
//   playing   : high while in PLAY
//   game_over : high while in OVER
// A request sampled at edge k is acked in cycle k+1; if that ack cycle is a
// PLAY cycle and the counter is not full, score_inc follows in cycle k+2.
// -----------------------------------------------------------------------------
module whack_score_ctrl
    import whack_pkg::*;
#(
    parameter int NUM_MOLES   = 4,
    parameter int ROUND_TICKS = 60
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 tick,
    input  logic [NUM_MOLES-1:0] hit_req,
    output logic [NUM_MOLES-1:0] hit_ack,
    input  logic [SCORE_W-1:0]   score,
    output logic                 score_clr,
    output logic                 score_inc,
    output logic [TIME_W-1:0]    time_left,
    output logic                 playing,
    output logic                 game_over
);

    state_t                 state;
    logic [NUM_MOLES-1:0]   grant;
    logic                   credit_hit;

    // Arbitration runs in every state. Masking with the current ack keeps a
    // requester that is still high during its ack cycle from a second grant.
    rr_arbiter #(
        .N(NUM_MOLES)
    ) u_arb (
        .clock   (clock),
        .reset   (reset),
        .req     (hit_req),
        .mask    (hit_ack),
        .advance (1'b1),
        .grant   (grant)
    );

    // The ack visible now is the grant being judged. Only PLAY-cycle acks
    // earn a point, and only while the counter has room.
    assign credit_hit = (|hit_ack) && (state == PLAY) &&
                        !score_saturated(score, score_inc);

    // Sequencer, timer and registered outputs. score_clr is only set on the
    // way into CLEAR, and CLEAR is always entered from IDLE or OVER where no
    // increment can be generated for the following cycle, so the two strobes
    // never coincide.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            hit_ack   <= '0;
            score_clr <= 1'b0;
            score_inc <= 1'b0;
            time_left <= '0;
            playing   <= 1'b0;
            game_over <= 1'b0;
        end else begin
            hit_ack   <= grant;
            score_inc <= credit_hit;
            score_clr <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (start) begin
                        state     <= CLEAR;
                        score_clr <= 1'b1;
                        time_left <= TIME_W'(ROUND_TICKS);
                        game_over <= 1'b0;
                    end
                end
                CLEAR: begin
                    state   <= PLAY;
                    playing <= 1'b1;
                end
                PLAY: begin
                    if (tick) begin
                        if (time_left == TIME_W'(1)) begin
                            state     <= OVER;
                            time_left <= '0;
                            playing   <= 1'b0;
                            game_over <= 1'b1;
                        end else begin
                            time_left <= time_left - TIME_W'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
